// File: rtl/sm3_msg_arb_pkg.sv
// Shared types and constants for the SM3 multi-requester message arbiter.
package sm3_arb_pkg;

  localparam int SM3_DGST_W  = 256;
  localparam int ARB_MAX_REQ = 4;
  localparam int GNT_W       = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MSG      = 2'd1,
    WAIT_RES = 2'd2,
    RESP     = 2'd3
  } arb_st_e;

endpackage

// File: rtl/sm3_msg_arb_if.sv
// Requester-side and core-side signal bundle of the SM3 message arbiter.
// master: the arbiter's view; slave: the surrounding requesters and core.
interface sm3_msg_arb_if import sm3_arb_pkg::*; #(
  parameter int REQ_NUM = 2,
  parameter int DW      = 32,
  parameter int BW      = DW / 8
);

  logic [REQ_NUM-1:0]    req_vld;
  logic [REQ_NUM*DW-1:0] req_d;
  logic [REQ_NUM*BW-1:0] req_vld_byte;
  logic [REQ_NUM-1:0]    req_lst;
  logic [REQ_NUM-1:0]    req_rdy;
  logic [REQ_NUM-1:0]    res_vld;
  logic [SM3_DGST_W-1:0] res;

  logic [DW-1:0]         msg_inpt_d;
  logic [BW-1:0]         msg_inpt_vld_byte;
  logic                  msg_inpt_vld;
  logic                  msg_inpt_lst;
  logic                  msg_inpt_rdy;
  logic                  cmprss_otpt_vld;
  logic [SM3_DGST_W-1:0] cmprss_otpt_res;

  modport master (
    input  req_vld, req_d, req_vld_byte, req_lst,
    input  msg_inpt_rdy, cmprss_otpt_vld, cmprss_otpt_res,
    output req_rdy, res_vld, res,
    output msg_inpt_d, msg_inpt_vld_byte, msg_inpt_vld, msg_inpt_lst
  );

  modport slave (
    output req_vld, req_d, req_vld_byte, req_lst,
    output msg_inpt_rdy, cmprss_otpt_vld, cmprss_otpt_res,
    input  req_rdy, res_vld, res,
    input  msg_inpt_d, msg_inpt_vld_byte, msg_inpt_vld, msg_inpt_lst
  );

endinterface

// File: rtl/sm3_msg_arb_pick.sv
// Combinational winner select: first asserted request found when scanning
// upward from the start index, wrapping at REQ_NUM.
module sm3_arb_pick import sm3_arb_pkg::*; #(
  parameter int REQ_NUM = 2
) (
  input  logic [REQ_NUM-1:0] req,
  input  logic [GNT_W-1:0]   start,
  output logic [GNT_W-1:0]   win,
  output logic               any
);

  int sidx;

  // rotating scan; the first hit wins and later hits are masked by any
  always_comb begin
    win  = '0;
    any  = 1'b0;
    sidx = 0;
    for (int i = 0; i < REQ_NUM; i++) begin
      sidx = int'(start) + i;
      if (sidx >= REQ_NUM) sidx = sidx - REQ_NUM;
      for (int j = 0; j < REQ_NUM; j++) begin
        if (!any && (j == sidx) && req[j]) begin
          win = GNT_W'(j);
          any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sm3_msg_arb.sv
// SM3 message arbiter: grants one of REQ_NUM requesters for a whole message,
// forwards its words to the core, waits for the digest and pulses it back
// to the owner.
// SM3_ARB_RR_EN : round-robin arbitration (otherwise fixed priority, index 0 highest).
// SM3_INPT_DW_64: 64-bit message words (otherwise 32-bit).
module sm3_msg_arb import sm3_arb_pkg::*; #(
  parameter int REQ_NUM = 2,
`ifdef SM3_INPT_DW_64
  parameter int DW      = 64,
`else
  parameter int DW      = 32,
`endif
  parameter int BW      = DW / 8
) (
  input  logic             clk,
  input  logic             rst,
  sm3_msg_arb_if.master    bus,
  output logic [GNT_W-1:0] gnt_id,
  output logic             busy
);

  arb_st_e               state_q, state_d;
  logic [GNT_W-1:0]      gnt_q;
  logic [GNT_W-1:0]      pick_start;
  logic [GNT_W-1:0]      pick_win;
  logic                  pick_any;
  logic [SM3_DGST_W-1:0] res_q;

`ifdef SM3_ARB_RR_EN
  logic [GNT_W-1:0]      last_gnt_q;

  assign pick_start = (last_gnt_q == GNT_W'(REQ_NUM - 1)) ? '0 : last_gnt_q + 1'b1;
`else
  assign pick_start = '0;
`endif

  sm3_arb_pick #(.REQ_NUM(REQ_NUM)) u_pick (
    .req   (bus.req_vld),
    .start (pick_start),
    .win   (pick_win),
    .any   (pick_any)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // grant owner (and round-robin pointer) captured when leaving IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q      <= '0;
`ifdef SM3_ARB_RR_EN
      last_gnt_q <= GNT_W'(REQ_NUM - 1);
`endif
    end else if (state_q == IDLE && pick_any) begin
      gnt_q      <= pick_win;
`ifdef SM3_ARB_RR_EN
      last_gnt_q <= pick_win;
`endif
    end
  end

  // digest capture; stray digests outside WAIT_RES leave res untouched
  always_ff @(posedge clk) begin
    if (rst)                                         res_q <= '0;
    else if (state_q == WAIT_RES && bus.cmprss_otpt_vld) res_q <= bus.cmprss_otpt_res;
  end

  // next state, owner routing onto the core port and result pulse
  always_comb begin
    state_d               = state_q;
    bus.msg_inpt_d        = '0;
    bus.msg_inpt_vld_byte = '0;
    bus.msg_inpt_vld      = 1'b0;
    bus.msg_inpt_lst      = 1'b0;
    bus.req_rdy           = '0;
    bus.res_vld           = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) state_d = MSG;
      end
      MSG: begin
        for (int k = 0; k < REQ_NUM; k++) begin
          if (GNT_W'(k) == gnt_q) begin
            bus.msg_inpt_d        = bus.req_d[k*DW +: DW];
            bus.msg_inpt_vld_byte = bus.req_vld_byte[k*BW +: BW];
            bus.msg_inpt_vld      = bus.req_vld[k];
            bus.msg_inpt_lst      = bus.req_lst[k];
            bus.req_rdy[k]        = bus.msg_inpt_rdy;
          end
        end
        if (bus.msg_inpt_vld && bus.msg_inpt_rdy && bus.msg_inpt_lst) state_d = WAIT_RES;
      end
      WAIT_RES: begin
        if (bus.cmprss_otpt_vld) state_d = RESP;
      end
      RESP: begin
        for (int k = 0; k < REQ_NUM; k++) begin
          if (GNT_W'(k) == gnt_q) bus.res_vld[k] = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.res = res_q;
  assign gnt_id  = gnt_q;
  assign busy    = (state_q == MSG) || (state_q == WAIT_RES);

endmodule
